// File: rtl/z80_dma_pkg.sv
// Shared constants for the tv80s block-copy DMA controller.
// FSM state codes, default burst/gap sizes and per-byte cycle length.
package z80_dma_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_WR2  = 3'd5;
    localparam logic [2:0] S_REL  = 3'd6;
    localparam logic [2:0] S_GAPW = 3'd7;

    localparam int BURST_DEF = 4;
    localparam int GAP_DEF   = 8;
    localparam int BYTE_CLKS = 4;

    // 16-bit address step; wraps FFFF to 0000
    function automatic logic [15:0] addr_inc(input logic [15:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/z80_bus_dma.sv
// Memory-to-memory block-copy DMA for the tv80s bus.
// Borrows the bus with busrq_n/busak_n, copies BURST bytes per tenure.
module z80_bus_dma
    import z80_dma_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bus_own,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_dout,
    input  logic [7:0]  dma_din,
    output logic        dma_mreq_n,
    output logic        dma_rd_n,
    output logic        dma_wr_n
);

    localparam logic [7:0] BURST_W  = 8'(BURST);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    logic [2:0]  state;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] len_q;
    logic [7:0]  burst_q;
    logic [7:0]  gap_q;
    logic        fin_q;

    logic [2:0]  state_d;
    logic [15:0] src_d;
    logic [15:0] dst_d;
    logic [15:0] len_d;
    logic [7:0]  burst_d;
    logic [7:0]  gap_d;
    logic        fin_d;
    logic        busy_d;
    logic        done_d;
    logic        busrq_d;
    logic        own_d;
    logic [15:0] a_d;
    logic [7:0]  dout_d;
    logic        mreq_d;
    logic        rd_d;
    logic        wr_d;

    logic [15:0] src_inc;
    logic [15:0] dst_inc;
    logic [7:0]  burst_inc;
    logic        last_byte;
    logic        burst_full;

    assign src_inc    = addr_inc(src_q);
    assign dst_inc    = addr_inc(dst_q);
    assign burst_inc  = burst_q + 8'd1;
    assign last_byte  = (len_q == 16'd1);
    assign burst_full = (burst_inc == BURST_W);

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d = state;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        fin_d   = fin_q;
        busy_d  = busy;
        done_d  = 1'b0;
        busrq_d = busrq_n;
        own_d   = bus_own;
        a_d     = dma_a;
        dout_d  = dma_dout;
        mreq_d  = dma_mreq_n;
        rd_d    = dma_rd_n;
        wr_d    = dma_wr_n;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != 16'd0) begin
                        src_d   = src;
                        dst_d   = dst;
                        len_d   = len;
                        burst_d = 8'd0;
                        busy_d  = 1'b1;
                        busrq_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (!busak_n) begin
                    own_d   = 1'b1;
                    a_d     = src_q;
                    mreq_d  = 1'b0;
                    rd_d    = 1'b0;
                    state_d = S_RD1;
                end
            end

            S_RD1: begin
                state_d = S_RD2;
            end

            // memory output is stable by the end of RD2
            S_RD2: begin
                a_d     = dst_q;
                dout_d  = dma_din;
                rd_d    = 1'b1;
                wr_d    = 1'b0;
                state_d = S_WR1;
            end

            S_WR1: begin
                mreq_d  = 1'b1;
                wr_d    = 1'b1;
                state_d = S_WR2;
            end

            S_WR2: begin
                src_d   = src_inc;
                dst_d   = dst_inc;
                len_d   = len_q - 16'd1;
                burst_d = burst_inc;
                if (last_byte || burst_full) begin
                    // drop ownership with the request so drivers never overlap
                    fin_d   = last_byte;
                    own_d   = 1'b0;
                    busrq_d = 1'b1;
                    state_d = S_REL;
                end else begin
                    a_d     = src_inc;
                    mreq_d  = 1'b0;
                    rd_d    = 1'b0;
                    state_d = S_RD1;
                end
            end

            S_REL: begin
                if (busak_n) begin
                    if (fin_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = 8'd0;
                        state_d = S_GAPW;
                    end
                end
            end

            S_GAPW: begin
                if (gap_q == GAP_LAST) begin
                    burst_d = 8'd0;
                    busrq_d = 1'b0;
                    state_d = S_REQ;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            src_q      <= 16'h0000;
            dst_q      <= 16'h0000;
            len_q      <= 16'h0000;
            burst_q    <= 8'd0;
            gap_q      <= 8'd0;
            fin_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            busrq_n    <= 1'b1;
            bus_own    <= 1'b0;
            dma_a      <= 16'h0000;
            dma_dout   <= 8'h00;
            dma_mreq_n <= 1'b1;
            dma_rd_n   <= 1'b1;
            dma_wr_n   <= 1'b1;
        end else begin
            state      <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            gap_q      <= gap_d;
            fin_q      <= fin_d;
            busy       <= busy_d;
            done       <= done_d;
            busrq_n    <= busrq_d;
            bus_own    <= own_d;
            dma_a      <= a_d;
            dma_dout   <= dout_d;
            dma_mreq_n <= mreq_d;
            dma_rd_n   <= rd_d;
            dma_wr_n   <= wr_d;
        end
    end

endmodule

// File: tb/tb_z80_bus_dma.sv
// Scoreboard bench for z80_bus_dma with a memory and CPU bus model.
// Expected writes are queued at start and popped per DMA write strobe.
module tb_z80_bus_dma;
    import z80_dma_pkg::*;

    localparam int BURST = 4;
    localparam int GAP   = 8;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src = 16'h0;
    logic [15:0] dst = 16'h0;
    logic [15:0] len = 16'h0;
    logic        busak_n = 1'b1;
    logic [7:0]  dma_din = 8'h00;
    logic        busy;
    logic        done;
    logic        busrq_n;
    logic        bus_own;
    logic [15:0] dma_a;
    logic [7:0]  dma_dout;
    logic        dma_mreq_n;
    logic        dma_rd_n;
    logic        dma_wr_n;

    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];
    wr_t        sb[$];
    int         per_bytes[$];
    int         gaps[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_total = 0;
    int done_cnt = 0;
    int dual_cnt = 0;
    int rq_cnt = 0;

    z80_bus_dma #(.BURST(BURST), .GAP(GAP)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .src(src),
        .dst(dst),
        .len(len),
        .busy(busy),
        .done(done),
        .busrq_n(busrq_n),
        .busak_n(busak_n),
        .bus_own(bus_own),
        .dma_a(dma_a),
        .dma_dout(dma_dout),
        .dma_din(dma_din),
        .dma_mreq_n(dma_mreq_n),
        .dma_rd_n(dma_rd_n),
        .dma_wr_n(dma_wr_n)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CPU model: grants the bus one cycle after the request changes
    initial begin
        logic rq_d;
        rq_d = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            busak_n = rq_d;
            rq_d = busrq_n;
        end
    end

    // Bus-level monitor: tenures, gaps, done pulses, dual drive
    initial begin
        logic prev_rq;
        int base;
        int hi;
        prev_rq = 1'b1;
        base = 0;
        hi = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) done_cnt++;
            if (bus_own && busrq_n) dual_cnt++;
            if (prev_rq && !busrq_n) begin
                rq_cnt++;
                gaps.push_back(hi);
                base = wr_total;
            end
            if (!prev_rq && busrq_n) begin
                per_bytes.push_back(wr_total - base);
                hi = 0;
            end
            if (busrq_n) hi++;
            prev_rq = busrq_n;
        end
    end

    // Memory model on the falling edge, plus scoreboard pop on writes
    initial begin
        int last_cyc;
        int last_rq;
        wr_t e;
        last_cyc = -100;
        last_rq = -1;
        forever begin
            @(negedge clk);
            if (!dma_mreq_n && !dma_rd_n) dma_din = mem[dma_a];
            if (!dma_mreq_n && !dma_wr_n) begin
                mem[dma_a] = dma_dout;
                wr_total++;
                chk("wr_own", bus_own, 1'b1);
                chk("wr_pending", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", dma_a, e.a);
                    chk("wr_data", dma_dout, e.d);
                end
                if (rq_cnt == last_rq)
                    chk("byte_clks", cyc - last_cyc, BYTE_CLKS);
                last_cyc = cyc;
                last_rq = rq_cnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        mem[a] = d;
        shadow[a] = d;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l);
        wr_t e;
        logic [15:0] sa;
        for (int i = 0; i < int'(l); i++) begin
            sa = s + 16'(i);
            e.a = d + 16'(i);
            e.d = shadow[sa];
            shadow[e.a] = e.d;
            sb.push_back(e);
        end
        @(posedge clk);
        #3;
        src = s;
        dst = d;
        len = l;
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < max) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk({tag, "_timeout"}, done_cnt != d0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        int d0;
        int r0;
        int p0;
        int g0;
        int w0;
        int n;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i ^ (i >> 8));
            shadow[i] = mem[i];
        end

        // reset values
        repeat (3) @(posedge clk);
        #3;
        chk("rst_ctl", {busy, done, busrq_n, bus_own}, 4'b0010);
        chk("rst_strb", {dma_mreq_n, dma_rd_n, dma_wr_n}, 3'b111);
        chk("rst_a", dma_a, 16'h0000);
        chk("rst_dout", dma_dout, 8'h00);
        reset_n = 1'b1;
        idle(2);

        // basic copy
        poke(16'h2000, 8'h11);
        poke(16'h2001, 8'h22);
        poke(16'h2002, 8'h33);
        d0 = done_cnt;
        r0 = rq_cnt;
        do_start(16'h2000, 16'h3000, 16'd3);
        chk("basic_busy", busy, 1'b1);
        chk("basic_rq", busrq_n, 1'b0);
        wait_done("basic", 200);
        chk("basic_busy_end", busy, 1'b0);
        idle(4);
        chk("basic_done_cnt", done_cnt - d0, 1);
        chk("basic_rq_cnt", rq_cnt - r0, 1);
        chk("basic_m0", mem[16'h3000], 8'h11);
        chk("basic_m2", mem[16'h3002], 8'h33);

        // zero length
        d0 = done_cnt;
        r0 = rq_cnt;
        do_start(16'h2000, 16'h3100, 16'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        idle(1);
        chk("zero_done_off", done, 1'b0);
        idle(6);
        chk("zero_rq", rq_cnt - r0, 0);
        chk("zero_done_cnt", done_cnt - d0, 1);

        // wrap-around
        poke(16'hFFFF, 8'hAA);
        poke(16'h0000, 8'hBB);
        do_start(16'hFFFF, 16'h4000, 16'd2);
        wait_done("wrap", 200);
        idle(2);
        chk("wrap_m0", mem[16'h4000], 8'hAA);
        chk("wrap_m1", mem[16'h4001], 8'hBB);

        // burst split
        for (int i = 0; i < 6; i++)
            poke(16'h8000 + 16'(i), 8'($urandom_range(0, 255)));
        p0 = per_bytes.size();
        g0 = gaps.size();
        r0 = rq_cnt;
        do_start(16'h8000, 16'h9000, 16'd6);
        wait_done("burst", 400);
        idle(3);
        chk("burst_tenures", rq_cnt - r0, 2);
        if (per_bytes.size() >= p0 + 2) begin
            chk("burst_b0", per_bytes[p0], BURST);
            chk("burst_b1", per_bytes[p0 + 1], 2);
        end
        if (gaps.size() >= g0 + 2)
            chk("burst_gap", gaps[g0 + 1] >= GAP, 1'b1);

        // start while busy
        poke(16'h6100, 8'hEE);
        d0 = done_cnt;
        do_start(16'h5000, 16'h6000, 16'd3);
        idle(3);
        src = 16'h5100;
        dst = 16'h6100;
        len = 16'd7;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        wait_done("busy_start", 300);
        idle(20);
        chk("busy_done_cnt", done_cnt - d0, 1);
        chk("busy_m2", mem[16'h6002], shadow[16'h6002]);
        chk("busy_untouched", mem[16'h6100], 8'hEE);

        // overlapping forward copy smears the first byte
        poke(16'h7000, 8'h5A);
        do_start(16'h7000, 16'h7001, 16'd3);
        wait_done("overlap", 200);
        idle(2);
        chk("overlap_m3", mem[16'h7003], 8'h5A);
        chk("sb_empty", sb.size(), 0);

        // reset during WR1 of byte 2
        for (int i = 0; i < 5; i++) begin
            poke(16'hA000 + 16'(i), 8'h40 + 8'(i));
            poke(16'hB000 + 16'(i), 8'hC3);
        end
        d0 = done_cnt;
        w0 = wr_total;
        do_start(16'hA000, 16'hB000, 16'd5);
        n = 0;
        begin
            int seen;
            logic pw;
            seen = 0;
            pw = 1'b1;
            while (seen < 2 && n < 300) begin
                @(posedge clk);
                #3;
                n++;
                if (!dma_wr_n && pw) seen++;
                pw = dma_wr_n;
            end
        end
        chk("rst_find_wr1", n < 300, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rq", busrq_n, 1'b1);
        chk("rst_mid_own", bus_own, 1'b0);
        chk("rst_mid_strb", {dma_mreq_n, dma_rd_n, dma_wr_n}, 3'b111);
        idle(2);
        reset_n = 1'b1;
        idle(20);
        sb.delete();
        chk("rst_busy", busy, 1'b0);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_wr_cnt", (wr_total - w0 >= 1) && (wr_total - w0 <= 2), 1'b1);
        chk("rst_m0", mem[16'hB000], 8'h40);
        chk("rst_m2", mem[16'hB002], 8'hC3);
        chk("rst_m4", mem[16'hB004], 8'hC3);

        chk("dual_drive", dual_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/z80_bus_dma.md
# z80_bus_dma

Memory-to-memory block-copy DMA controller for the tv80s system bus. It requests the bus from the CPU via `busrq_n`/`busak_n`, drives the 64 KB memory with its own address and strobes while it owns the bus, and returns the bus to the CPU between bursts. It sits beside `tv80s` in the top level, and its `bus_own` output selects between CPU and DMA drivers on the shared memory port.

## Interface
- `BURST`, 4, maximum bytes copied per bus tenure (1..255).
- `GAP`, 8, minimum clocks the bus is left with the CPU between tenures (1..255).

- `clk`  in  1  system clock, same as the CPU clock.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse; latches `src`/`dst`/`len`.
- `src`  in  16  source start address.
- `dst`  in  16  destination start address.
- `len`  in  16  byte count; 0 is a no-op.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `busrq_n`  out  1  to CPU `busrq_n`.
- `busak_n`  in  1  from CPU `busak_n`.
- `bus_own`  out  1  1 = DMA drives the memory port.
- `dma_a`  out  16  memory address.
- `dma_dout`  out  8  write data.
- `dma_din`  in  8  read data (memory output, updated on the falling clock edge).
- `dma_mreq_n`, `dma_rd_n`, `dma_wr_n`  out  1 each  memory strobes.

## Operation
- States: IDLE, REQ, RD1, RD2, WR1, WR2, REL, GAPW.
- IDLE: on `start` with `len`≠0, latch the parameters, set the burst counter to 0, and go to REQ. With `len`=0, pulse `done` next cycle; `busy` stays low and `busrq_n` is untouched.
- `start` while `busy` is ignored and does not change the latched parameters.
- REQ: `busrq_n`=0. Wait for `busak_n`=0 sampled at a rising edge, then go to RD1 with `bus_own`=1.
- RD1: `dma_a`=src, `dma_mreq_n`=0, `dma_rd_n`=0. RD2: strobes held; latch `dma_din` at the end of RD2.
- WR1: `dma_a`=dst, `dma_dout`=latched byte, `dma_mreq_n`=0, `dma_wr_n`=0. WR2: strobes high, `dma_a`/`dma_dout` held.
- At the end of WR2: src+1, dst+1 (16-bit wrap, FFFF→0000), len−1, burst+1.
  - If len reaches 0: go to REL (final).
  - Else if burst reaches `BURST`: go to REL (intermediate).
  - Else: go to RD1.
- REL: `bus_own`=0 and `busrq_n`=1 from the REL cycle onward.
  - Final: wait for `busak_n`=1, pulse `done`, then go to IDLE.
  - Intermediate: wait for `busak_n`=1, then go to GAPW.
- GAPW: count `GAP` clocks, reset the burst counter, then go to REQ.
- `busak_n` rising while DMA owns the bus is a protocol error: ignored, no recovery required.
- Overlapping src/dst ranges copy forward byte-by-byte with no special handling.

## Timing
- Reset values: `busy`=0, `done`=0, `busrq_n`=1, `bus_own`=0, `dma_a`=0000, `dma_dout`=00, all strobes=1. Reset applies immediately (asynchronous), including mid-transfer. A transfer in progress is discarded.
- All outputs are registered.
- `start` at edge N → `busy`=1 and `busrq_n`=0 after edge N+1.
- Each byte takes 4 clocks (RD1, RD2, WR1, WR2) once `busak_n` is low.
- The memory write occurs on the falling edge inside WR1.
- `bus_own` is low no later than the cycle `busrq_n` goes high, so there is no dual drive.
- `done` is asserted exactly one cycle, in the cycle after `busak_n`=1 is sampled in final REL. `busy` falls together with `done`.

## Structure
- Package `z80_dma_pkg`: state enum, `BURST`/`GAP` default constants, byte-cycle length constant (4).
- Single module. No natural sub-module: the address counters, byte counter, burst counter and gap counter sit inline with the FSM.
- Top level: `cpu_a`/strobes muxed with `dma_*` by `bus_own`; `cpu_busak_n` wired to `busak_n`.

## Test plan
- Basic copy: mem[2000..2002]=11,22,33, CPU running NOPs; start src=2000 dst=3000 len=3 → mem[3000..3002]=11,22,33, one `busrq_n` low period, `done` once, CPU PC resumes advancing.
- Zero length: `start` with len=0 → `done` exactly 1 cycle later, `busrq_n` never low, `busy` stays low.
- Wrap-around: src=FFFF, dst=4000, len=2, mem[FFFF]=AA, mem[0000]=BB (CPU code elsewhere) → mem[4000]=AA, mem[4001]=BB.
- Burst split: `BURST`=4, `GAP`=8, len=6 → two `busrq_n` low periods carrying 4 and 2 bytes; `busrq_n` high ≥8 clocks between them; destination bytes all correct.
- Reset mid-transfer: assert `reset_n`=0 during WR1 of byte 2 of len=5 → `busrq_n`=1, `bus_own`=0, strobes=1 immediately. After release, `busy`=0 and exactly 1 or 2 destination bytes are written, none beyond.
- Start while busy: second `start` during a len=3 transfer → ignored, single `done`, original parameters used.
